multicycle_ctrl: RTL and testbench

//  Main FSM of the multi-cycle MIPS-subset CPU; replaces the single-cycle opcode decode.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/mc_wait_timer.sv | 38 +++
 rtl/multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_pkg                                                          |
// | Purpose : Shared constants for the multi-cycle MIPS-subset CPU: opcodes,  |
// |           controller state encodings, ALU_op, PCSource and ALUSrcB codes.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    // Opcode field IR[31:26]
    localparam logic [5:0] c_OP_R_TYPE = 6'b000000;
    localparam logic [5:0] c_OP_J      = 6'b000010;
    localparam logic [5:0] c_OP_BEQ    = 6'b000100;
    localparam logic [5:0] c_OP_BNE    = 6'b000101;
    localparam logic [5:0] c_OP_ADDI   = 6'b001000;
    localparam logic [5:0] c_OP_SLTI   = 6'b001010;
    localparam logic [5:0] c_OP_ORI    = 6'b001101;
    localparam logic [5:0] c_OP_LUI    = 6'b001111;
    localparam logic [5:0] c_OP_LW     = 6'b100011;
    localparam logic [5:0] c_OP_SW     = 6'b101011;

    // Controller states (also exported on state_o)
    localparam logic [3:0] c_S_FETCH  = 4'd0;
    localparam logic [3:0] c_S_DECODE = 4'd1;
    localparam logic [3:0] c_S_MEMADR = 4'd2;
    localparam logic [3:0] c_S_MEMRD  = 4'd3;
    localparam logic [3:0] c_S_MEMWB  = 4'd4;
    localparam logic [3:0] c_S_MEMWR  = 4'd5;
    localparam logic [3:0] c_S_REX    = 4'd6;
    localparam logic [3:0] c_S_RWB    = 4'd7;
    localparam logic [3:0] c_S_BRANCH = 4'd8;
    localparam logic [3:0] c_S_IEX    = 4'd9;
    localparam logic [3:0] c_S_IWB    = 4'd10;
    localparam logic [3:0] c_S_JUMP   = 4'd11;

    // ALU operation select
    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_FUNCT = 3'b010;
    localparam logic [2:0] c_ALU_ADDI  = 3'b100;
    localparam logic [2:0] c_ALU_SLTI  = 3'b101;
    localparam logic [2:0] c_ALU_LUI   = 3'b110;
    localparam logic [2:0] c_ALU_ORI   = 3'b111;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] c_SRCB_RT      = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mc_wait_timer                                                    |
// | Purpose : Memory wait-cycle counter. Counts cycles while enable_i is high, |
// |           returns to zero when clear_i is high; expired_o flags a count    |
// |           equal to WAIT_MAX.                                               |
// | Ports   : clk_i, rst_i (async, active-high), clear_i, enable_i, expired_o  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int c_CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(WAIT_MAX);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (enable_i) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired_o = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : multicycle_ctrl                                                  |
// | Purpose : Main controller of the multi-cycle MIPS-subset CPU. Sequences    |
// |           fetch/decode/execute/memory/writeback over a shared ALU and a    |
// |           shared req/ready memory port, counts retired instructions and    |
// |           flags illegal opcodes and memory wait timeouts.                  |
// | Ports   : clk_i, rst_i (async, active-high), instr_op_i, mem_ready_i in;   |
// |           memory request, datapath selects/enables, illegal_o, bus_err_o,  |
// |           instr_cnt_o, state_o out.                                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             IorD_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic             Not_equal_o,
    output logic [1:0]       PCSource_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic             Signed_o,
    output logic [2:0]       ALU_op_o,
    output logic             RegDst_o,
    output logic             MemtoReg_o,
    output logic             RegWrite_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] instr_cnt_o,
    output logic [3:0]       state_o
);

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_instr_cnt;
    logic [3:0]       w_state_next;
    logic             w_retire;
    logic             w_wait_state;
    logic             w_expired;
    logic             w_timer_en;

    logic       w_mem_req, w_mem_we, w_iord, w_irwrite, w_pcwrite, w_pcwritecond;
    logic       w_not_equal, w_alusrca, w_signed, w_regdst, w_memtoreg, w_regwrite;
    logic       w_illegal, w_bus_err;
    logic [1:0] w_pcsource, w_alusrcb;
    logic [2:0] w_alu_op;

    // The timer only runs while a memory state keeps waiting; any other cycle
    // clears it, so every entry into FETCH/MEMRD/MEMWR starts from zero.
    assign w_wait_state = (r_state == c_S_FETCH) || (r_state == c_S_MEMRD) ||
                          (r_state == c_S_MEMWR);
    assign w_timer_en   = w_wait_state && !mem_ready_i && !w_expired;

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!w_timer_en),
        .enable_i  (w_timer_en),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= c_S_FETCH;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and per-state controls; opcode-dependent fields use the live opcode.
    always_comb begin
        w_state_next  = r_state;
        w_retire      = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_iord        = 1'b0;
        w_irwrite     = 1'b0;
        w_pcwrite     = 1'b0;
        w_pcwritecond = 1'b0;
        w_not_equal   = 1'b0;
        w_pcsource    = c_PCSRC_ALU;
        w_alusrca     = 1'b0;
        w_alusrcb     = c_SRCB_RT;
        w_signed      = 1'b0;
        w_alu_op      = c_ALU_ADD;
        w_regdst      = 1'b0;
        w_memtoreg    = 1'b0;
        w_regwrite    = 1'b0;
        w_illegal     = 1'b0;
        w_bus_err     = 1'b0;

        case (r_state)
            c_S_FETCH: begin
                w_mem_req = 1'b1;
                w_alusrcb = c_SRCB_FOUR;
                if (mem_ready_i) begin
                    w_irwrite    = 1'b1;
                    w_pcwrite    = 1'b1;
                    w_state_next = c_S_DECODE;
                end else if (w_expired) begin
                    // Timeout: PC untouched, so the same address is refetched.
                    w_bus_err    = 1'b1;
                    w_state_next = c_S_FETCH;
                end
            end
            c_S_DECODE: begin
                w_alusrcb = c_SRCB_IMM_SH2;
                case (instr_op_i)
                    c_OP_LW, c_OP_SW:                       w_state_next = c_S_MEMADR;
                    c_OP_R_TYPE:                            w_state_next = c_S_REX;
                    c_OP_BEQ, c_OP_BNE:                     w_state_next = c_S_BRANCH;
                    c_OP_ADDI, c_OP_SLTI, c_OP_LUI, c_OP_ORI: w_state_next = c_S_IEX;
                    c_OP_J:                                 w_state_next = c_S_JUMP;
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = c_S_FETCH;
                    end
                endcase
            end
            c_S_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = c_SRCB_IMM;
                w_signed     = 1'b1;
                w_state_next = (instr_op_i == c_OP_SW) ? c_S_MEMWR : c_S_MEMRD;
            end
            c_S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (mem_ready_i) begin
                    w_state_next = c_S_MEMWB;
                end else if (w_expired) begin
                    w_bus_err    = 1'b1;
                    w_state_next = c_S_FETCH;
                end
            end
            c_S_MEMWB: begin
                w_regwrite   = 1'b1;
                w_memtoreg   = 1'b1;
                w_retire     = 1'b1;
                w_state_next = c_S_FETCH;
            end
            c_S_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_iord    = 1'b1;
                if (mem_ready_i) begin
                    w_retire     = 1'b1;
                    w_state_next = c_S_FETCH;
                end else if (w_expired) begin
                    w_bus_err    = 1'b1;
                    w_state_next = c_S_FETCH;
                end
            end
            c_S_REX: begin
                w_alusrca    = 1'b1;
                w_alu_op     = c_ALU_FUNCT;
                w_state_next = c_S_RWB;
            end
            c_S_RWB: begin
                w_regwrite   = 1'b1;
                w_regdst     = 1'b1;
                w_retire     = 1'b1;
                w_state_next = c_S_FETCH;
            end
            c_S_BRANCH: begin
                w_alusrca     = 1'b1;
                w_alu_op      = c_ALU_SUB;
                w_pcwritecond = 1'b1;
                w_pcsource    = c_PCSRC_ALUOUT;
                w_not_equal   = (instr_op_i == c_OP_BNE);
                w_retire      = 1'b1;
                w_state_next  = c_S_FETCH;
            end
            c_S_IEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_SRCB_IMM;
                w_signed  = (instr_op_i != c_OP_ORI);
                case (instr_op_i)
                    c_OP_ADDI: w_alu_op = c_ALU_ADDI;
                    c_OP_SLTI: w_alu_op = c_ALU_SLTI;
                    c_OP_LUI:  w_alu_op = c_ALU_LUI;
                    c_OP_ORI:  w_alu_op = c_ALU_ORI;
                    default:   w_alu_op = c_ALU_ADD;
                endcase
                w_state_next = c_S_IWB;
            end
            c_S_IWB: begin
                w_regwrite   = 1'b1;
                w_retire     = 1'b1;
                w_state_next = c_S_FETCH;
            end
            c_S_JUMP: begin
                w_pcwrite    = 1'b1;
                w_pcsource   = c_PCSRC_JUMP;
                w_retire     = 1'b1;
                w_state_next = c_S_FETCH;
            end
            default: begin
                w_state_next = c_S_FETCH;
            end
        endcase
    end

    // Reset forces every control low immediately, abandoning any in-flight access.
    assign mem_req_o     = w_mem_req     & ~rst_i;
    assign mem_we_o      = w_mem_we      & ~rst_i;
    assign IorD_o        = w_iord        & ~rst_i;
    assign IRWrite_o     = w_irwrite     & ~rst_i;
    assign PCWrite_o     = w_pcwrite     & ~rst_i;
    assign PCWriteCond_o = w_pcwritecond & ~rst_i;
    assign Not_equal_o   = w_not_equal   & ~rst_i;
    assign PCSource_o    = w_pcsource    & {2{~rst_i}};
    assign ALUSrcA_o     = w_alusrca     & ~rst_i;
    assign ALUSrcB_o     = w_alusrcb     & {2{~rst_i}};
    assign Signed_o      = w_signed      & ~rst_i;
    assign ALU_op_o      = w_alu_op      & {3{~rst_i}};
    assign RegDst_o      = w_regdst      & ~rst_i;
    assign MemtoReg_o    = w_memtoreg    & ~rst_i;
    assign RegWrite_o    = w_regwrite    & ~rst_i;
    assign illegal_o     = w_illegal     & ~rst_i;
    assign bus_err_o     = w_bus_err     & ~rst_i;
    assign instr_cnt_o   = r_instr_cnt;
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_multicycle_ctrl                                               |
// | Purpose : Self-checking bench for multicycle_ctrl. Instructions are issued |
// |           as transactions (opcode, fetch latency, memory latency); the     |
// |           expected state walk, controls and retire count come from a       |
// |           per-instruction path model built from the opcode class.          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;   // narrow so the wrap to zero is reachable

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwritecond;
        logic       not_equal;
        logic [1:0] pcsource;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       sgn;
        logic [2:0] alu_op;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       instr_op;
    logic             mem_ready;
    logic             mem_req, mem_we, iord, irwrite, pcwrite, pcwritecond, not_equal;
    logic [1:0]       pcsource, alusrcb;
    logic             alusrca, sgn, regdst, memtoreg, regwrite, illegal, bus_err;
    logic [2:0]       alu_op;
    logic [CNT_W-1:0] instr_cnt;
    logic [3:0]       state;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;

    logic [5:0] legal_ops [10] = '{6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b001010,
                                   6'b001111, 6'b001101, 6'b100011, 6'b101011, 6'b000010};

    multicycle_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_op_i    (instr_op),
        .mem_ready_i   (mem_ready),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .IorD_o        (iord),
        .IRWrite_o     (irwrite),
        .PCWrite_o     (pcwrite),
        .PCWriteCond_o (pcwritecond),
        .Not_equal_o   (not_equal),
        .PCSource_o    (pcsource),
        .ALUSrcA_o     (alusrca),
        .ALUSrcB_o     (alusrcb),
        .Signed_o      (sgn),
        .ALU_op_o      (alu_op),
        .RegDst_o      (regdst),
        .MemtoReg_o    (memtoreg),
        .RegWrite_o    (regwrite),
        .illegal_o     (illegal),
        .bus_err_o     (bus_err),
        .instr_cnt_o   (instr_cnt),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        for (int i = 0; i < 10; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Control table: what each numbered state must drive.
    function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op,
                                       input logic rdy, input logic tmo);
        ctrl_t c = '0;
        case (st)
            0:  begin c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy;
                      c.bus_err = tmo; end
            1:  begin c.alusrcb = 2'b11; c.illegal = !is_legal(op); end
            2:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.sgn = 1; end
            3:  begin c.mem_req = 1; c.iord = 1; c.bus_err = tmo; end
            4:  begin c.regwrite = 1; c.memtoreg = 1; end
            5:  begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; c.bus_err = tmo; end
            6:  begin c.alusrca = 1; c.alu_op = 3'b010; end
            7:  begin c.regwrite = 1; c.regdst = 1; end
            8:  begin c.alusrca = 1; c.alu_op = 3'b001; c.pcwritecond = 1; c.pcsource = 2'b01;
                      c.not_equal = (op == 6'b000101); end
            9:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.sgn = (op != 6'b001101);
                      case (op)
                          6'b001000: c.alu_op = 3'b100;
                          6'b001010: c.alu_op = 3'b101;
                          6'b001111: c.alu_op = 3'b110;
                          default:   c.alu_op = 3'b111;
                      endcase
                end
            10: begin c.regwrite = 1; end
            11: begin c.pcwrite = 1; c.pcsource = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t observed();
        return {mem_req, mem_we, iord, irwrite, pcwrite, pcwritecond, not_equal, pcsource,
                alusrca, alusrcb, sgn, alu_op, regdst, memtoreg, regwrite, illegal, bus_err};
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, wait for the next fall.
    task automatic step(input int st, input logic [5:0] op, input logic rdy, input logic tmo);
        instr_op  = op;
        mem_ready = rdy;
        #1;
        check_eq($sformatf("state(exp %0d)", st), 64'(state), 64'(st));
        check_eq($sformatf("ctrl(st %0d)", st), 64'(observed()), 64'(exp_ctrl(st, op, rdy, tmo)));
        check_eq("instr_cnt", 64'(instr_cnt), 64'(model_cnt % (1 << CNT_W)));
        @(negedge clk);
    endtask

    // Memory-waiting state: ready arrives after lat idle cycles unless the wait budget runs out.
    task automatic wait_phase(input int st, input int lat, input logic [5:0] op, output bit ok);
        for (int c = 0; c <= WAIT_MAX; c++) begin
            logic rdy, tmo;
            rdy = (c == lat);
            tmo = (c == WAIT_MAX) && !rdy;
            step(st, op, rdy, tmo);
            if (rdy) begin ok = 1'b1; return; end
        end
        ok = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input int lat_f, input int lat_m);
        bit ok;
        wait_phase(0, lat_f, 6'($urandom), ok);
        if (!ok) return;
        step(1, op, 1'($urandom), 1'b0);
        if (!is_legal(op)) return;
        case (op)
            6'b100011, 6'b101011: begin
                step(2, op, 1'($urandom), 1'b0);
                wait_phase((op == 6'b100011) ? 3 : 5, lat_m, op, ok);
                if (!ok) return;
                if (op == 6'b100011) step(4, op, 1'($urandom), 1'b0);
            end
            6'b000000: begin step(6, op, 1'($urandom), 1'b0); step(7, op, 1'($urandom), 1'b0); end
            6'b000100, 6'b000101: step(8, op, 1'($urandom), 1'b0);
            6'b000010: step(11, op, 1'($urandom), 1'b0);
            default: begin step(9, op, 1'($urandom), 1'b0); step(10, op, 1'($urandom), 1'b0); end
        endcase
        model_cnt++;
    endtask

    task automatic reset_mid_memrd();
        bit ok;
        wait_phase(0, 0, 6'($urandom), ok);
        step(1, 6'b100011, 1'b0, 1'b0);
        step(2, 6'b100011, 1'b0, 1'b0);
        instr_op  = 6'b100011;
        mem_ready = 1'b0;
        #1;
        check_eq("memrd_state", 64'(state), 64'd3);
        check_eq("memrd_req", 64'(mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_req", 64'(mem_req), 64'd0);
        check_eq("async_rst_state", 64'(state), 64'd0);
        check_eq("async_rst_cnt", 64'(instr_cnt), 64'd0);
        check_eq("async_rst_ctrl", 64'(observed()), 64'd0);
        model_cnt = 0;
        @(negedge clk);
        check_eq("rst_hold_ctrl", 64'(observed()), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        instr_op  = '0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset_state", 64'(state), 64'd0);
        check_eq("reset_cnt", 64'(instr_cnt), 64'd0);
        check_eq("reset_ctrl", 64'(observed()), 64'd0);
        rst = 1'b0;

        run_instr(6'b000000, 0, 0);    // add
        run_instr(6'b100011, 3, 3);    // lw, late ready
        run_instr(6'b000101, 0, 0);    // bne
        run_instr(6'b001101, 1, 0);    // ori
        run_instr(6'b111111, 0, 0);    // illegal
        run_instr(6'b101011, 0, 99);   // sw, timeout in MEMWR
        run_instr(6'b000000, 99, 0);   // fetch timeout
        run_instr(6'b101011, 15, 15);  // ready on the last allowed cycle
        run_instr(6'b000100, 0, 0);    // beq
        run_instr(6'b001010, 2, 0);    // slti
        run_instr(6'b001111, 0, 0);    // lui
        run_instr(6'b001000, 0, 0);    // addi
        run_instr(6'b000010, 0, 0);    // j
        reset_mid_memrd();

        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            int r, lf, lm;
            r  = $urandom_range(0, 11);
            op = (r < 10) ? legal_ops[r] : 6'($urandom);
            lf = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(13, 18);
            lm = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(13, 18);
            run_instr(op, lf, lm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
